proc_feeder: RTL and testbench

Instruction issuer for the 9-bit `proc` datapath. It holds a small program memory and drives the processor's `DIN`/`Run` inputs one instruction at a time. For `mvi` it also supplies the immediate word, then waits for the processor's `Done` before issuing the next instruction. It sits between the board-level loader and the processor, and replaces the manual switch/Run stimulus.

---
 rtl/proc_feeder.sv | 173 +++++++++++++++++
 tb/tb_proc_feeder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_feeder.sv
// proc_feeder: issues instructions from a small program memory to the 9-bit proc datapath.
// Drives DIN/Run one instruction at a time. For mvi it also supplies the immediate word.
// It then waits for Done, and drops Run for one GAP cycle between instructions.
// Optional feature: define PROC_FEEDER_TIMEOUT_EN to halt with Error when Done never arrives.
module proc_feeder #(
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [8:0]    WrData,
  input  logic          Start,
  input  logic          Stop,
  input  logic          Done,
  output logic [8:0]    DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [7:0]    Count
);

  typedef enum logic [2:0] {StIdle, StIssue, StImm, StWait, StGap, StHalt} state_t;

  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpHalt = 3'b111;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [8:0]    din_q, din_d;
  logic          run;
  logic          tmo_hit;
  logic [8:0]    mem [2**AW];
  logic [8:0]    rd_word;

  assign rd_word = mem[pc_q];
  assign Busy    = (state_q != StIdle) && (state_q != StHalt);
  assign Halted  = (state_q == StHalt);
  assign PC      = pc_q;
  assign Count   = cnt_q;
  assign DIN     = din_d;
  // Run is decoded from the state register so an asynchronous reset drops it immediately.
  assign Run     = run;

  // Program memory: no reset, write-only while not busy; reads see the old word on a write edge.
  always_ff @(posedge Clock) begin
    if (WrEn && !Busy) begin
      mem[WrAddr] <= WrData;
    end
  end

`ifdef PROC_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT));
  assign Error   = err_q;

  // Timeout counter runs while waiting for Done; Error is sticky until the next Start.
  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if ((state_q == StIdle || state_q == StHalt) && Start) begin
      err_d = 1'b0;
      tmo_d = '0;
    end else if (state_q == StIssue) begin
      tmo_d = '0;
    end else if ((state_q == StImm || state_q == StWait) && !Done) begin
      if (tmo_hit) begin
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Timeout state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign Error          = 1'b0;
`endif

  // Next-state, fetch and issue outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    run     = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (Start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (rd_word[8:6] == OpHalt) begin
          state_d = StHalt;
        end else begin
          din_d   = rd_word;
          run     = 1'b1;
          pc_d    = pc_q + AW'(1);
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
          state_d = (rd_word[8:6] == OpMvi) ? StImm : StWait;
        end
      end
      StImm: begin
        din_d = rd_word;
        run   = 1'b1;
        pc_d  = pc_q + AW'(1);
        if (Done) begin
          state_d = StGap;
        end else if (tmo_hit) begin
          state_d = StHalt;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        run = 1'b1;
        if (Done) begin
          state_d = StGap;
        end else if (tmo_hit) begin
          state_d = StHalt;
        end
      end
      StGap: begin
        state_d = Stop ? StHalt : StIssue;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Main state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_proc_feeder.sv
// Self-checking bench for proc_feeder: directed programs, scoreboard of issued DIN words.
module tb_proc_feeder;
  localparam int AW = 5;

  logic          Clock  = 1'b0;
  logic          Reset  = 1'b1;
  logic          WrEn   = 1'b0;
  logic [AW-1:0] WrAddr = '0;
  logic [8:0]    WrData = '0;
  logic          Start  = 1'b0;
  logic          Stop   = 1'b0;
  logic          Done;
  logic [8:0]    DIN;
  logic          Run;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [7:0]    Count;

  logic       auto_done = 1'b0;
  logic       run_prev;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];

  proc_feeder #(.AW(AW), .TIMEOUT(15)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .WrEn  (WrEn),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .Start (Start),
    .Stop  (Stop),
    .Done  (Done),
    .DIN   (DIN),
    .Run   (Run),
    .PC    (PC),
    .Busy  (Busy),
    .Halted(Halted),
    .Error (Error),
    .Count (Count)
  );

  always #5 Clock = ~Clock;

  // Processor model: Done in T1, i.e. the second consecutive Run cycle.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) run_prev <= 1'b0;
    else       run_prev <= Run;
  end
  assign Done = auto_done & Run & run_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a new word is presented on the first Run cycle, plus the next one for mvi.
  task automatic monitor();
    logic       prev = 1'b0;
    logic       imm_pend = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge Clock);
      if (Run && (!prev || imm_pend)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL din_unexpected: got %0d, expected no word", DIN);
          imm_pend = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("din", 32'(DIN), 32'(e));
          if (imm_pend) imm_pend = 1'b0;
          else          imm_pend = (e[8:6] == 3'b001);
        end
      end else begin
        imm_pend = 1'b0;
      end
      prev = Run;
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [8:0] d);
    WrEn   = 1'b1;
    WrAddr = AW'(a);
    WrData = d;
    tick();
    WrEn   = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_halted(input int budget, input string name);
    int n = 0;
    while (!Halted && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(Halted), 32'd1);
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int n = 0;
    while (Count != 8'(target) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(Count), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"},    32'(DIN),    32'd0);
    check({tag, "_run"},    32'(Run),    32'd0);
    check({tag, "_pc"},     32'(PC),     32'd0);
    check({tag, "_busy"},   32'(Busy),   32'd0);
    check({tag, "_halted"}, 32'(Halted), 32'd0);
    check({tag, "_error"},  32'(Error),  32'd0);
    check({tag, "_count"},  32'(Count),  32'd0);
  endtask

  task automatic load_program();
    write_mem(0, 9'o103);
    write_mem(1, 9'd5);
    write_mem(2, 9'o010);
    write_mem(3, 9'o700);
  endtask

  task automatic push_prog();
    exp_q.push_back(9'o103);
    exp_q.push_back(9'd5);
    exp_q.push_back(9'o010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset values.
    #12;
    check_reset_outputs("reset");
    Reset = 1'b0;
    tick();

    // Start and WrEn together in IDLE: the HALT word is written before the first fetch.
    WrEn   = 1'b1;
    WrAddr = '0;
    WrData = 9'o700;
    Start  = 1'b1;
    tick();
    WrEn   = 1'b0;
    Start  = 1'b0;
    check("busy_in_issue", 32'(Busy), 32'd1);
    wait_halted(5, "start_wr_halt");
    check("start_wr_count", 32'(Count), 32'd0);
    check("start_wr_pc", 32'(PC), 32'd0);

    // Basic program: mvi R0,#5; mv R1,R0; halt.
    load_program();
    push_prog();
    auto_done = 1'b1;
    pulse_start();
    check("run_after_start", 32'(Run), 32'd1);
    wait_halted(30, "prog_halt");
    check("prog_count", 32'(Count), 32'd2);
    check("prog_pc", 32'(PC), 32'd3);
    check("prog_busy", 32'(Busy), 32'd0);

    // Start and WrEn while busy are ignored.
    push_prog();
    auto_done = 1'b0;
    pulse_start();
    tick();
    tick();
    check("pc_in_wait", 32'(PC), 32'd2);
    Start  = 1'b1;
    WrEn   = 1'b1;
    WrAddr = AW'(2);
    WrData = 9'o020;
    tick();
    Start  = 1'b0;
    WrEn   = 1'b0;
    check("busy_start_pc", 32'(PC), 32'd2);
    check("busy_start_count", 32'(Count), 32'd1);
    check("busy_start_run", 32'(Run), 32'd1);
    auto_done = 1'b1;
    wait_halted(30, "busy_prog_halt");
    check("busy_prog_count", 32'(Count), 32'd2);

    // Stop held high: halt after the first GAP.
    exp_q.push_back(9'o103);
    exp_q.push_back(9'd5);
    Stop = 1'b1;
    pulse_start();
    wait_halted(30, "stop_halt");
    Stop = 1'b0;
    check("stop_count", 32'(Count), 32'd1);
    check("stop_pc", 32'(PC), 32'd2);

    // Wrap-around: 32 mv words, no HALT, 40 instructions.
    for (int i = 0; i < 32; i++) write_mem(i, 9'(i));
    for (int k = 0; k < 40; k++) exp_q.push_back(9'(k % 32));
    pulse_start();
    wait_count(40, 200, "wrap_count_reach");
    Stop = 1'b1;
    wait_halted(10, "wrap_halt");
    Stop = 1'b0;
    check("wrap_count", 32'(Count), 32'd40);
    check("wrap_pc", 32'(PC), 32'd8);

    // Saturation: 258 instructions, Count stays at 255.
    for (int k = 0; k < 258; k++) exp_q.push_back(9'(k % 32));
    pulse_start();
    wait_count(255, 1000, "sat_count_reach");
    repeat (9) tick();
    check("sat_hold", 32'(Count), 32'd255);
    Stop = 1'b1;
    wait_halted(10, "sat_halt");
    Stop = 1'b0;
    check("sat_count", 32'(Count), 32'd255);
    check("sat_pc", 32'(PC), 32'd2);

    // Reset in WAIT: outputs clear at once, memory survives.
    load_program();
    exp_q.push_back(9'o103);
    exp_q.push_back(9'd5);
    auto_done = 1'b0;
    pulse_start();
    tick();
    tick();
    check("pre_reset_run", 32'(Run), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    Reset = 1'b0;
    tick();
    push_prog();
    auto_done = 1'b1;
    pulse_start();
    wait_halted(30, "after_reset_halt");
    check("after_reset_count", 32'(Count), 32'd2);
    check("after_reset_pc", 32'(PC), 32'd3);

    // Done withheld.
    exp_q.push_back(9'o103);
    exp_q.push_back(9'd5);
    auto_done = 1'b0;
    pulse_start();
    repeat (16) tick();
    check("tmo_run_16", 32'(Run), 32'd1);
    check("tmo_err_16", 32'(Error), 32'd0);
    tick();
`ifdef PROC_FEEDER_TIMEOUT_EN
    check("tmo_error", 32'(Error), 32'd1);
    check("tmo_halted", 32'(Halted), 32'd1);
    check("tmo_run", 32'(Run), 32'd0);
    push_prog();
    auto_done = 1'b1;
    pulse_start();
    check("tmo_error_cleared", 32'(Error), 32'd0);
`else
    check("notmo_run", 32'(Run), 32'd1);
    check("notmo_halted", 32'(Halted), 32'd0);
    repeat (40) tick();
    check("notmo_run_long", 32'(Run), 32'd1);
    check("notmo_error", 32'(Error), 32'd0);
    exp_q.push_back(9'o010);
    auto_done = 1'b1;
`endif
    wait_halted(30, "tmo_final_halt");
    check("tmo_final_count", 32'(Count), 32'd2);
    check("tmo_final_pc", 32'(PC), 32'd3);

    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
